spi_regfile_periph: RTL

Parameterised SPI-mode-0 peripheral giving a controller read and write access to a bank of NUM_REGS configuration registers, each DATA_W bits wide. All SPI pins are synchronised into the clk domain. Writes commit only on a clean, exact-length frame. Reads return register contents on CIPO in the same frame. The flat register bus feeds the PWM/output-enable logic.

---
 rtl/spi_regfile_periph.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral exposing a bank of NUM_REGS x DATA_W configuration registers.
// Frame: R/W bit (1 = write), address, data, MSB first; writes commit only on clean exact-length frames.
module spi_regfile_periph #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ncs,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_ADDR_M1 = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_ADDR    = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_OVR     = CNT_W'(FRAME_W + 1);

  logic [SYNC_STAGES-1:0] ncs_sync, sclk_sync, copi_sync, flush_sr;
  logic                   armed;

  // ncs idles high through reset so reset release can never fake a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_sync  <= '1;
      sclk_sync <= '0;
      copi_sync <= '0;
      flush_sr  <= '0;
      armed     <= 1'b0;
    end else begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      flush_sr  <= {flush_sr[SYNC_STAGES-2:0], 1'b1};
      // Only arm once the chain holds real pin samples and ncs has been seen high.
      armed     <= armed | (flush_sr[SYNC_STAGES-1] & ncs_sync[SYNC_STAGES-1]);
    end
  end

  logic ncs_fall, ncs_rise, sclk_rise, sclk_fall, copi_bit, start_evt, end_evt;
  assign ncs_fall  =  ncs_sync[SYNC_STAGES-1]  & ~ncs_sync[SYNC_STAGES-2];
  assign ncs_rise  = ~ncs_sync[SYNC_STAGES-1]  &  ncs_sync[SYNC_STAGES-2];
  assign sclk_rise = ~sclk_sync[SYNC_STAGES-1] &  sclk_sync[SYNC_STAGES-2];
  assign sclk_fall =  sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES-2];
  assign copi_bit  =  copi_sync[SYNC_STAGES-1];

  logic                       active;
  logic [CNT_W-1:0]           bit_cnt;
  logic [FRAME_W-1:0]         rx_q, rx_next;
  logic [DATA_W-1:0]          tx_q, rd_data, fr_data;
  logic [ADDR_W-1:0]          rd_addr, fr_addr;
  logic                       fr_write, addr_ok, frame_ok, reject;
  logic [NUM_REGS-1:0]        wr_hit;
  logic [NUM_REGS*DATA_W-1:0] regs_q;

  assign start_evt = ncs_fall & armed;
  assign end_evt   = ncs_rise & active;
  assign rx_next   = {rx_q[FRAME_W-2:0], copi_bit};
  assign rd_addr   = rx_next[ADDR_W-1:0];
  assign fr_write  = rx_q[FRAME_W-1];
  assign fr_addr   = rx_q[FRAME_W-2 -: ADDR_W];
  assign fr_data   = rx_q[DATA_W-1:0];

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    rd_data = '0;
    addr_ok = 1'b0;
    wr_hit  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i*DATA_W +: DATA_W];
      if (fr_addr == ADDR_W'(i)) addr_ok = 1'b1;
    end
    frame_ok = (bit_cnt == CNT_FULL) && addr_ok;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = frame_ok && fr_write && (fr_addr == ADDR_W'(i));
    end
    reject = (bit_cnt != '0) && !frame_ok;
  end

  // NOTE: the register bank is reset because downstream PWM logic relies on a known image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      bit_cnt   <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      cipo_oe   <= 1'b0;
      regs_q    <= RESET_VAL;
      wr_strobe <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= '0;
      frame_err <= 1'b0;
      if (start_evt) begin
        active  <= 1'b1;
        bit_cnt <= '0;
        rx_q    <= '0;
        cipo_oe <= 1'b0;
      end else if (end_evt) begin
        active    <= 1'b0;
        cipo_oe   <= 1'b0;
        wr_strobe <= wr_hit;
        frame_err <= reject;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_hit[i]) regs_q[i*DATA_W +: DATA_W] <= fr_data;
        end
      end else if (active) begin
        if (sclk_rise) begin
          if (bit_cnt < CNT_FULL) begin
            rx_q    <= rx_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
            // Address just completed on a read: present the addressed register.
            if (bit_cnt == CNT_ADDR_M1 && !rx_next[ADDR_W]) begin
              tx_q    <= rd_data;
              cipo_oe <= 1'b1;
            end
          end else begin
            bit_cnt <= CNT_OVR;
          end
        end else if (sclk_fall && cipo_oe && bit_cnt > CNT_ADDR && bit_cnt < CNT_FULL) begin
          tx_q <= {tx_q[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign cipo     = cipo_oe & tx_q[DATA_W-1];
  assign regs_out = regs_q;

endmodule
